// File: rtl/sad_best_match.sv
// Best-match tracker downstream of the SAD engine: follows the running minimum SAD over a frame
// and presents one best-match record on a valid/ready handshake when the frame ends.
module sad_best_match #(
  parameter int ADDR_WIDTH = 7,
  parameter int SAD_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8,
  parameter logic [SAD_WIDTH-1:0] THRESHOLD = 32'h00000400
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Go,
  input  logic                  In_Valid,
  input  logic [ADDR_WIDTH-1:0] In_Addr,
  input  logic [SAD_WIDTH-1:0]  In_Sad,
  input  logic                  In_Last,
  output logic                  Best_Valid,
  input  logic                  Best_Ready,
  output logic [ADDR_WIDTH-1:0] Best_Addr,
  output logic [SAD_WIDTH-1:0]  Best_Sad,
  output logic                  Best_None,
  output logic [CNT_WIDTH-1:0]  Match_Cnt,
  output logic                  Busy,
  output logic                  Err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  localparam logic [SAD_WIDTH-1:0]  SAD_ONES  = {SAD_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONES  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [SAD_WIDTH-1:0]    min_r, min_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
  logic                    seen_r, seen_s;
  logic                    none_r, none_s;
  logic                    err_r, err_s;
  logic                    valid_r, busy_r;

  // Next-state and frame accumulator update
  always_comb begin
    state_s = state_r;
    min_s   = min_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    seen_s  = seen_r;
    none_s  = none_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (Go) begin
          state_s = ST_COLLECT;
          min_s   = SAD_ONES;
          addr_s  = ADDR_ZERO;
          cnt_s   = CNT_ZERO;
          seen_s  = 1'b0;
          none_s  = 1'b0;
          err_s   = 1'b0;
        end else if (In_Valid) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end
      ST_COLLECT: begin
        // A restart drops any sample arriving with it; Last takes priority over Go
        if (Go && !In_Last) begin
          min_s  = SAD_ONES;
          addr_s = ADDR_ZERO;
          cnt_s  = CNT_ZERO;
          seen_s = 1'b0;
        end else begin
          if (In_Valid) begin
            if (In_Sad < min_r) begin
              min_s  = In_Sad;
              addr_s = In_Addr;
            end else begin
              min_s  = min_r;
              addr_s = addr_r;
            end
            if ((In_Sad <= THRESHOLD) && (cnt_r != CNT_ONES)) begin
              cnt_s = cnt_r + CNT_ONE;
            end else begin
              cnt_s = cnt_r;
            end
            seen_s = 1'b1;
          end else begin
            seen_s = seen_r;
          end
          if (In_Last) begin
            state_s = ST_REPORT;
            none_s  = !(seen_r || In_Valid);
          end else begin
            state_s = ST_COLLECT;
          end
        end
      end
      ST_REPORT: begin
        if (In_Valid) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (Best_Ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, record and status registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      min_r   <= SAD_ONES;
      addr_r  <= ADDR_ZERO;
      cnt_r   <= CNT_ZERO;
      seen_r  <= 1'b0;
      none_r  <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      min_r   <= min_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
      seen_r  <= seen_s;
      none_r  <= none_s;
      err_r   <= err_s;
      valid_r <= (state_s == ST_REPORT);
      busy_r  <= (state_s == ST_COLLECT);
    end
  end

  assign Best_Valid = valid_r;
  assign Best_Addr  = addr_r;
  assign Best_Sad   = min_r;
  assign Best_None  = none_r;
  assign Match_Cnt  = cnt_r;
  assign Busy       = busy_r;
  assign Err        = err_r;

endmodule
